ascon_perm_arbiter: RTL

Round-robin arbiter and round sequencer that shares one ASCON permutation round datapath between two requesters, e.g. the AEAD controller and a hash/XOF controller. It takes a 320-bit state and a round-count select from the granted requester, drives the datapath's `intial`/`inc`/`consti` controls for p^12 or p^6, then returns the permuted state with a one-cycle `done` pulse. It sits between the requester controllers and the round datapath, replacing their direct connection.

---
 rtl/ascon_perm_arbiter_if.sv | 26 ++
 rtl/ascon_perm_arbiter.sv | 126 ++++++++++++
 2 files changed

// File: rtl/ascon_perm_arbiter_if.sv
// Requester-side bundle of the ASCON permutation arbiter: two request/ack/done
// channels plus the shared result bus.
interface ascon_perm_arbiter_if;
  logic         req0;
  logic         req1;
  logic         nr0;
  logic         nr1;
  logic [319:0] st0;
  logic [319:0] st1;
  logic         ack0;
  logic         ack1;
  logic         done0;
  logic         done1;
  logic [319:0] dout;
  logic         busy;

  modport master (
    output req0, req1, nr0, nr1, st0, st1,
    input  ack0, ack1, done0, done1, dout, busy
  );

  modport slave (
    input  req0, req1, nr0, nr1, st0, st1,
    output ack0, ack1, done0, done1, dout, busy
  );
endinterface

// File: rtl/ascon_perm_arbiter.sv
// Round-robin arbiter and round sequencer sharing one ASCON round datapath
// between two requesters; runs p^12 or p^6 and returns the permuted state.
module ascon_perm_arbiter (
  input  logic        clk,
  input  logic        rst,
  ascon_perm_arbiter_if.slave bus,
  output logic        intial,
  output logic        inc,
  output logic [3:0]  consti,
  output logic [63:0] Xi0,
  output logic [63:0] Xi1,
  output logic [63:0] Xi2,
  output logic [63:0] Xi3,
  output logic [63:0] Xi4,
  input  logic [63:0] Xo0,
  input  logic [63:0] Xo1,
  input  logic [63:0] Xo2,
  input  logic [63:0] Xo3,
  input  logic [63:0] Xo4
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  localparam logic [3:0] LAST_ROUND = 4'd11;

  state_t        state_reg, state_next;
  logic          owner_reg, owner_next;
  logic          last_reg, last_next;
  logic [3:0]    rnd_reg, rnd_next;
  logic [319:0]  dout_reg, dout_next;
  logic [1:0]    done_reg, done_next;
  logic [1:0]    ack;
  logic          grant;
  logic          grant_nr;
  logic [319:0]  xi;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= IDLE;
      owner_reg <= 1'b0;
      last_reg  <= 1'b1;
      rnd_reg   <= 4'd0;
      dout_reg  <= 320'd0;
      done_reg  <= 2'b00;
    end else begin
      state_reg <= state_next;
      owner_reg <= owner_next;
      last_reg  <= last_next;
      rnd_reg   <= rnd_next;
      dout_reg  <= dout_next;
      done_reg  <= done_next;
    end
  end

  // On a tie the requester that was not granted last time wins.
  always_comb begin
    if (bus.req0 && bus.req1) begin
      grant = ~last_reg;
    end else begin
      grant = bus.req1;
    end
    grant_nr = grant ? bus.nr1 : bus.nr0;
  end

  always_comb begin
    state_next = state_reg;
    owner_next = owner_reg;
    last_next  = last_reg;
    rnd_next   = rnd_reg;
    dout_next  = dout_reg;
    done_next  = 2'b00;
    intial     = 1'b0;
    inc        = 1'b0;
    consti     = 4'd0;
    ack        = 2'b00;
    xi         = bus.st0;

    case (state_reg)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          owner_next = grant;
          last_next  = grant;
          rnd_next   = grant_nr ? 4'd0 : 4'd6;
          state_next = LOAD;
        end
      end
      LOAD: begin
        intial          = 1'b1;
        consti          = rnd_reg;
        xi              = owner_reg ? bus.st1 : bus.st0;
        ack[owner_reg]  = 1'b1;
        rnd_next        = rnd_reg + 4'd1;
        state_next      = RUN;
      end
      RUN: begin
        inc    = 1'b1;
        consti = rnd_reg;
        // Clear at the last round so the counter never leaves 0..11.
        if (rnd_reg == LAST_ROUND) begin
          rnd_next   = 4'd0;
          state_next = DONE;
        end else begin
          rnd_next = rnd_reg + 4'd1;
        end
      end
      DONE: begin
        dout_next            = {Xo0, Xo1, Xo2, Xo3, Xo4};
        done_next[owner_reg] = 1'b1;
        state_next           = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign {Xi0, Xi1, Xi2, Xi3, Xi4} = xi;

  assign bus.ack0  = ack[0];
  assign bus.ack1  = ack[1];
  assign bus.done0 = done_reg[0];
  assign bus.done1 = done_reg[1];
  assign bus.dout  = dout_reg;
  assign bus.busy  = (state_reg != IDLE);

endmodule
